// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use hazard detection
//
// Purpose:
//   Captures a decoded instruction from ID each cycle and presents ALU operands
//   to EX. The operands are forwarded from EX/MEM or MEM/WB when needed. A
//   bubble is inserted on a load-use hazard or an EX flush.
//
// Optional feature:
//   ID_EX_PERF_EN adds the free-running, wrapping counters perf_stall_cnt and
//   perf_flush_cnt.
//
// Ports:
//   clk, rst                                  clock; asynchronous active-high reset
//   id_valid .. id_mem_wr                     decoded instruction from ID
//   ex_flush                                  taken branch/jump resolved in EX
//   exm_rd, exm_reg_we, exm_result            EX/MEM forwarding source
//   mwb_rd, mwb_reg_we, mwb_result            MEM/WB forwarding source
//   id_stall                                  hold PC and IF/ID (combinational)
//   ex_valid, ex_pc, ex_rd, ex_reg_we,
//   ex_mem_rd, ex_mem_wr                      registered EX state
//   alu_a, alu_b, alu_op, ex_store_data       forwarded ALU operands and store data
//   perf_stall_cnt, perf_flush_cnt            event counters (ID_EX_PERF_EN only)

module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [3:0]      id_alu_op,
    input  logic            id_a_sel,
    input  logic            id_b_sel,
    input  logic            id_reg_we,
    input  logic            id_mem_rd,
    input  logic            id_mem_wr,
    input  logic            ex_flush,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_reg_we,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic            mwb_reg_we,
    input  logic [XLEN-1:0] mwb_result,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_rd,
    output logic            ex_reg_we,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    // EX-stage state
    logic            valid_q,  valid_d;
    logic [XLEN-1:0] pc_q,     pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,    imm_d;
    logic [RA_W-1:0] rs1_q,    rs1_d;
    logic [RA_W-1:0] rs2_q,    rs2_d;
    logic [RA_W-1:0] rd_q,     rd_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic            a_sel_q,  a_sel_d;
    logic            b_sel_q,  b_sel_d;
    logic            reg_we_q, reg_we_d;
    logic            mem_rd_q, mem_rd_d;
    logic            mem_wr_q, mem_wr_d;

    logic            hazard;
    logic            rs1_hit;
    logic            rs2_hit;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A load in EX whose data is not yet available; the dependent ID
    // instruction must wait one cycle until the load reaches EX/MEM.
    always_comb begin
        rs1_hit = id_use_rs1 && (id_rs1 == rd_q);
        rs2_hit = id_use_rs2 && (id_rs2 == rd_q);
        hazard  = valid_q && mem_rd_q && (rd_q != '0) && id_valid && (rs1_hit || rs2_hit);
    end

    // Flush wins over the stall: the ID instruction is on the wrong path, so
    // there is no point in holding it.
    assign id_stall = hazard && !ex_flush;

    // Next-state: capture, or bubble (controls cleared, data held).
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        alu_op_d   = alu_op_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        reg_we_d   = reg_we_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;

        if (ex_flush || hazard) begin
            valid_d  = 1'b0;
            reg_we_d = 1'b0;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            alu_op_d   = id_alu_op;
            a_sel_d    = id_a_sel;
            b_sel_d    = id_b_sel;
            // Qualified so no side effect can leak from an invalid slot.
            reg_we_d   = id_reg_we && id_valid;
            mem_rd_d   = id_mem_rd && id_valid;
            mem_wr_d   = id_mem_wr && id_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_op_q   <= '0;
            a_sel_q    <= 1'b0;
            b_sel_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            alu_op_q   <= alu_op_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            reg_we_q   <= reg_we_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    // Forwarding: the younger producer (EX/MEM) has priority. x0 is never
    // forwarded because it is hard-wired to zero in the register file.
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exm_reg_we && (exm_rd != '0) && (exm_rd == rs1_q)) begin
            fwd_rs1 = exm_result;
        end else if (mwb_reg_we && (mwb_rd != '0) && (mwb_rd == rs1_q)) begin
            fwd_rs1 = mwb_result;
        end

        fwd_rs2 = rs2_data_q;
        if (exm_reg_we && (exm_rd != '0) && (exm_rd == rs2_q)) begin
            fwd_rs2 = exm_result;
        end else if (mwb_reg_we && (mwb_rd != '0) && (mwb_rd == rs2_q)) begin
            fwd_rs2 = mwb_result;
        end
    end

    assign alu_a         = a_sel_q ? pc_q  : fwd_rs1;
    assign alu_b         = b_sel_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_op        = alu_op_q;
    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_reg_we     = reg_we_q;
    assign ex_mem_rd     = mem_rd_q;
    assign ex_mem_wr     = mem_wr_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stall_cnt_q;
    logic [31:0] perf_flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            if (id_stall) begin
                perf_stall_cnt_q <= perf_stall_cnt_q + 32'd1;
            end
            if (ex_flush) begin
                perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
    logic            id_use_rs1, id_use_rs2;
    logic [3:0]      id_alu_op;
    logic            id_a_sel, id_b_sel, id_reg_we, id_mem_rd, id_mem_wr;
    logic            ex_flush;
    logic [RA_W-1:0] exm_rd, mwb_rd;
    logic            exm_reg_we, mwb_reg_we;
    logic [XLEN-1:0] exm_result, mwb_result;
    logic            id_stall, ex_valid;
    logic [XLEN-1:0] ex_pc, alu_a, alu_b, ex_store_data;
    logic [3:0]      alu_op;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_we, ex_mem_rd, ex_mem_wr;
`ifdef ID_EX_PERF_EN
    logic [31:0]     perf_stall_cnt, perf_flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_alu_op(id_alu_op), .id_a_sel(id_a_sel),
        .id_b_sel(id_b_sel), .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd),
        .id_mem_wr(id_mem_wr), .ex_flush(ex_flush),
        .exm_rd(exm_rd), .exm_reg_we(exm_reg_we), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_we(mwb_reg_we), .mwb_result(mwb_result),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
`ifdef ID_EX_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // One clock edge; outputs are sampled 1 time unit afterwards.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_alu_op = 0; id_a_sel = 0; id_b_sel = 0; id_reg_we = 0;
        id_mem_rd = 0; id_mem_wr = 0; ex_flush = 0;
        exm_rd = 0; exm_reg_we = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_we = 0; mwb_result = 0;
    endtask

    // Plain R-type ALU instruction reading rs1 and rs2.
    task automatic present_alu(input logic [31:0] pc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [31:0] d1,
                               input logic [4:0] rs2, input logic [31:0] d2);
        id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs1_data = d1;
        id_rs2 = rs2; id_rs2_data = d2; id_use_rs1 = 1; id_use_rs2 = 1;
        id_imm = 32'h0000_0100; id_alu_op = 4'h1; id_a_sel = 0; id_b_sel = 0;
        id_reg_we = 1; id_mem_rd = 0; id_mem_wr = 0;
    endtask

    task automatic present_load(input logic [4:0] rd);
        id_valid = 1; id_pc = 32'h200; id_rd = rd; id_rs1 = 5'd1; id_rs1_data = 32'h1000;
        id_rs2 = 0; id_rs2_data = 0; id_use_rs1 = 1; id_use_rs2 = 0;
        id_imm = 32'h4; id_alu_op = 4'h0; id_a_sel = 0; id_b_sel = 1;
        id_reg_we = 1; id_mem_rd = 1; id_mem_wr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #3;
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #2;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got=%0h want=0", ex_valid); end
        n_cmp++; if (alu_a !== 32'h0) begin n_bad++; $display("FAIL reset_alu_a got=%0h want=0", alu_a); end
        n_cmp++; if (alu_op !== 4'h0) begin n_bad++; $display("FAIL reset_alu_op got=%0h want=0", alu_op); end
        @(negedge clk);
        rst = 0;
        // Run an instruction in, then reset asynchronously mid-cycle.
        present_alu(32'h44, 5'd9, 5'd1, 32'h5, 5'd2, 32'h7);
        step();
        n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid got=%0h want=1", ex_valid); end
        n_cmp++; if (ex_pc !== 32'h44) begin n_bad++; $display("FAIL pre_reset_pc got=%0h want=44", ex_pc); end
        rst = 1;
        #1;
        n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_valid got=%0h want=0", ex_valid); end
        n_cmp++; if (ex_pc !== 32'h0) begin n_bad++; $display("FAIL midrun_reset_pc got=%0h want=0", ex_pc); end
        n_cmp++; if ({ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr} !== 8'h0) begin n_bad++; $display("FAIL midrun_reset_ctrl got=%0h want=0", {ex_rd, ex_reg_we, ex_mem_rd, ex_mem_wr}); end
        n_cmp++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin n_bad++; $display("FAIL midrun_reset_ops got=%0h/%0h want=0/0", alu_a, alu_b); end
        n_cmp++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL midrun_reset_stall got=%0h want=0", id_stall); end
        #2;
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_forward_exm();
        present_alu(32'h100, 5'd3, 5'd1, 32'h5, 5'd2, 32'h7);   // add x3,x1,x2
        step();
        n_cmp++; if (alu_a !== 32'h5 || alu_b !== 32'h7) begin n_bad++; $display("FAIL plain_ops got=%0h/%0h want=5/7", alu_a, alu_b); end
        present_alu(32'h104, 5'd4, 5'd3, 32'h99, 5'd1, 32'h5);  // add x4,x3,x1
        n_cmp++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL exm_no_stall got=%0h want=0", id_stall); end
        step();
        exm_rd = 5'd3; exm_reg_we = 1; exm_result = 32'h10;
        #1;
        n_cmp++; if (alu_a !== 32'h10) begin n_bad++; $display("FAIL exm_fwd_a got=%0h want=10", alu_a); end
        n_cmp++; if (alu_b !== 32'h5) begin n_bad++; $display("FAIL exm_fwd_b got=%0h want=5", alu_b); end
        n_cmp++; if (ex_rd !== 5'd4 || ex_pc !== 32'h104) begin n_bad++; $display("FAIL exm_fields got=%0h/%0h want=4/104", ex_rd, ex_pc); end
        clear_inputs();
    endtask

    task automatic test_forward_priority();
        present_alu(32'h300, 5'd8, 5'd5, 32'h33, 5'd5, 32'h33);
        step();
        exm_rd = 5'd5; exm_reg_we = 1; exm_result = 32'hAA;
        mwb_rd = 5'd5; mwb_reg_we = 1; mwb_result = 32'hBB;
        #1;
        n_cmp++; if (alu_a !== 32'hAA) begin n_bad++; $display("FAIL prio_exm got=%0h want=aa", alu_a); end
        exm_reg_we = 0;
        #1;
        n_cmp++; if (alu_a !== 32'hBB) begin n_bad++; $display("FAIL prio_mwb got=%0h want=bb", alu_a); end
        n_cmp++; if (ex_store_data !== 32'hBB) begin n_bad++; $display("FAIL mwb_store got=%0h want=bb", ex_store_data); end
        // x0 sources with both producers claiming rd=0.
        present_alu(32'h304, 5'd8, 5'd0, 32'h44, 5'd0, 32'h55);
        exm_rd = 0; exm_reg_we = 1; mwb_rd = 0; mwb_reg_we = 1;
        step();
        n_cmp++; if (alu_a !== 32'h44) begin n_bad++; $display("FAIL x0_no_fwd got=%0h want=44", alu_a); end
        // Immediate/PC selects; store data still sees forwarded rs2.
        present_alu(32'h308, 5'd8, 5'd9, 32'h1, 5'd10, 32'h2);
        id_a_sel = 1; id_b_sel = 1; id_imm = 32'hFFFF_FFF0; id_mem_wr = 1; id_reg_we = 0;
        exm_reg_we = 0; mwb_reg_we = 0;
        step();
        exm_rd = 5'd10; exm_reg_we = 1; exm_result = 32'hCAFE;
        #1;
        n_cmp++; if (alu_a !== 32'h308) begin n_bad++; $display("FAIL asel_pc got=%0h want=308", alu_a); end
        n_cmp++; if (alu_b !== 32'hFFFF_FFF0) begin n_bad++; $display("FAIL bsel_imm got=%0h want=fffffff0", alu_b); end
        n_cmp++; if (ex_store_data !== 32'hCAFE) begin n_bad++; $display("FAIL store_fwd got=%0h want=cafe", ex_store_data); end
        n_cmp++; if (ex_mem_wr !== 1'b1 || ex_reg_we !== 1'b0) begin n_bad++; $display("FAIL store_ctrl got=%0h%0h want=10", ex_mem_wr, ex_reg_we); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        present_load(5'd6);
        step();
        present_alu(32'h204, 5'd7, 5'd1, 32'h5, 5'd6, 32'h0);  // add x7,x1,x6
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got=%0h want=1", id_stall); end
        step();
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_we !== 1'b0) begin n_bad++; $display("FAIL lu_bubble got=%0h%0h want=00", ex_valid, ex_reg_we); end
        n_cmp++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL lu_one_cycle got=%0h want=0", id_stall); end
        mwb_rd = 5'd6; mwb_reg_we = 1; mwb_result = 32'h77;
        step();
        n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin n_bad++; $display("FAIL lu_issue got=%0h/%0h want=1/7", ex_valid, ex_rd); end
        n_cmp++; if (alu_b !== 32'h77) begin n_bad++; $display("FAIL lu_fwd got=%0h want=77", alu_b); end
        clear_inputs();
        // Same pattern, rs2 not actually read.
        present_load(5'd6);
        step();
        present_alu(32'h208, 5'd7, 5'd1, 32'h5, 5'd6, 32'h0);
        id_use_rs2 = 0;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL lu_unused got=%0h want=0", id_stall); end
        clear_inputs();
        step();
    endtask

    task automatic test_flush_hazard();
        present_load(5'd6);
        step();
        present_alu(32'h20C, 5'd7, 5'd6, 32'h0, 5'd2, 32'h0);
        ex_flush = 1;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%0h want=0", id_stall); end
        step();
        n_cmp++; if (ex_valid !== 1'b0 || ex_mem_rd !== 1'b0) begin n_bad++; $display("FAIL flush_bubble got=%0h%0h want=00", ex_valid, ex_mem_rd); end
        clear_inputs();
        // Reset during an active stall drops id_stall at once.
        present_load(5'd6);
        step();
        present_alu(32'h210, 5'd7, 5'd6, 32'h0, 5'd2, 32'h0);
        #1;
        n_cmp++; if (id_stall !== 1'b1) begin n_bad++; $display("FAIL prereset_stall got=%0h want=1", id_stall); end
        rst = 1;
        #1;
        n_cmp++; if (id_stall !== 1'b0) begin n_bad++; $display("FAIL reset_mid_stall got=%0h want=0", id_stall); end
        #1;
        rst = 0;
        clear_inputs();
    endtask

`ifdef ID_EX_PERF_EN
    task automatic test_perf();
        clear_inputs();
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            present_load(5'd6);
            step();
            present_alu(32'h400, 5'd7, 5'd6, 32'h0, 5'd2, 32'h0);
            step();
            clear_inputs();
            step();
        end
        for (int i = 0; i < 2; i++) begin
            ex_flush = 1;
            step();
            ex_flush = 0;
            step();
        end
        n_cmp++; if (perf_stall_cnt !== 32'd3) begin n_bad++; $display("FAIL perf_stall got=%0d want=3", perf_stall_cnt); end
        n_cmp++; if (perf_flush_cnt !== 32'd2) begin n_bad++; $display("FAIL perf_flush got=%0d want=2", perf_flush_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        @(negedge clk);
        test_forward_exm();
        test_forward_priority();
        test_load_use();
        test_flush_hazard();
`ifdef ID_EX_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
